ir_fetch_queue: RTL

IR_FETCH_QUEUE -- requirements
Module: ir_fetch_queue

---
 rtl/ir_fetch_queue_pkg.sv | 59 +++++
 rtl/ir_fetch_queue_if.sv | 42 ++++
 rtl/ir_field_decode.sv | 67 ++++++
 rtl/ir_fetch_queue.sv | 104 ++++++++++
 4 files changed

// File: rtl/ir_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds the opcode map, the instruction format enumeration, the bit
// positions of every instruction field and a helper that classifies an
// opcode into its format.
package ir_pkg;

    localparam int OPC_W   = 5;
    localparam int C_W     = 19;
    localparam int C2_W    = 4;
    localparam int JADDR_W = 23;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 27;
    localparam int RA_MSB    = 26;
    localparam int RA_LSB    = 23;
    localparam int RB_MSB    = 22;
    localparam int RB_LSB    = 19;
    localparam int RC_MSB    = 18;
    localparam int RC_LSB    = 15;
    localparam int C_MSB     = 18;
    localparam int C2_MSB    = 22;
    localparam int C2_LSB    = 19;
    localparam int JADDR_MSB = 22;

    // Opcode map: range boundaries of each format group.
    localparam logic [OPC_W-1:0] OP_I_LO_LAST  = 5'd2;
    localparam logic [OPC_W-1:0] OP_R_LAST     = 5'd11;
    localparam logic [OPC_W-1:0] OP_I_HI_LAST  = 5'd14;
    localparam logic [OPC_W-1:0] OP_I2_LAST    = 5'd18;
    localparam logic [OPC_W-1:0] OP_BR         = 5'd19;
    localparam logic [OPC_W-1:0] OP_J_LAST     = 5'd21;
    localparam logic [OPC_W-1:0] OP_IO_LAST    = 5'd25;
    localparam logic [OPC_W-1:0] OP_NOP        = 5'd26;
    localparam logic [OPC_W-1:0] OP_HALT       = 5'd27;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_R,
        FMT_I2,
        FMT_B,
        FMT_J,
        FMT_IO,
        FMT_MISC,
        FMT_ILLEGAL
    } fmt_e;

    function automatic fmt_e fmt_of(input logic [OPC_W-1:0] op);
        if (op <= OP_I_LO_LAST)    return FMT_I;
        else if (op <= OP_R_LAST)  return FMT_R;
        else if (op <= OP_I_HI_LAST) return FMT_I;
        else if (op <= OP_I2_LAST) return FMT_I2;
        else if (op == OP_BR)      return FMT_B;
        else if (op <= OP_J_LAST)  return FMT_J;
        else if (op <= OP_IO_LAST) return FMT_IO;
        else if (op <= OP_HALT)    return FMT_MISC;
        else                       return FMT_ILLEGAL;
    endfunction

endpackage

// File: rtl/ir_fetch_queue_if.sv
// Bus bundle between the fetch queue and its producer/consumer.
// master: drives Flush, in_valid, BusMuxOut, out_ready (the environment).
// slave : drives in_ready, out_valid, IR, decoded fields, Illegal, count.
interface ir_fetch_queue_if
    import ir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int REG_W  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                Flush;
    logic                in_valid;
    logic [DATA_W-1:0]   BusMuxOut;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   IR;
    logic [OPC_W-1:0]    Opcode;
    logic [REG_W-1:0]    Ra;
    logic [REG_W-1:0]    Rb;
    logic [REG_W-1:0]    Rc;
    logic [C_W-1:0]      C;
    logic [C2_W-1:0]     C2;
    logic [JADDR_W-1:0]  Jaddr;
    logic                Illegal;
    logic [CNT_W-1:0]    count;

    modport master (
        output Flush, in_valid, BusMuxOut, out_ready,
        input  in_ready, out_valid, IR, Opcode, Ra, Rb, Rc, C, C2, Jaddr,
               Illegal, count
    );

    modport slave (
        input  Flush, in_valid, BusMuxOut, out_ready,
        output in_ready, out_valid, IR, Opcode, Ra, Rb, Rc, C, C2, Jaddr,
               Illegal, count
    );

endinterface

// File: rtl/ir_field_decode.sv
// Combinational instruction field extractor.
// In : ir      raw instruction word
// Out: opcode, ra, rb, rc, c, c2, jaddr, illegal -- fields not used by
//      the instruction's format are driven to zero.
module ir_field_decode
    import ir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic [DATA_W-1:0]  ir,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   ra,
    output logic [REG_W-1:0]   rb,
    output logic [REG_W-1:0]   rc,
    output logic [C_W-1:0]     c,
    output logic [C2_W-1:0]    c2,
    output logic [JADDR_W-1:0] jaddr,
    output logic               illegal
);
    logic [REG_W-1:0] ra_f, rb_f, rc_f;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign ra_f   = REG_W'(ir[RA_MSB:RA_LSB]);
    assign rb_f   = REG_W'(ir[RB_MSB:RB_LSB]);
    assign rc_f   = REG_W'(ir[RC_MSB:RC_LSB]);

    always_comb begin
        ra      = '0;
        rb      = '0;
        rc      = '0;
        c       = '0;
        c2      = '0;
        jaddr   = '0;
        illegal = 1'b0;
        case (fmt_of(opcode))
            FMT_I: begin
                ra = ra_f;
                rb = rb_f;
                c  = ir[C_MSB:0];
            end
            FMT_R: begin
                ra = ra_f;
                rb = rb_f;
                rc = rc_f;
            end
            FMT_I2: begin
                ra = ra_f;
                rb = rb_f;
            end
            FMT_B: begin
                ra = ra_f;
                c2 = ir[C2_MSB:C2_LSB];
                c  = ir[C_MSB:0];
            end
            FMT_J: begin
                ra    = ra_f;
                rb    = rb_f;
                jaddr = ir[JADDR_MSB:0];
            end
            FMT_IO:      ra = ra_f;
            FMT_MISC:    ;
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ir_fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry FIFO followed by a registered
// presentation stage that holds the head instruction together with its
// decoded fields.
// Ports: Clock, Clear (sync, active-high); bus (slave modport) carries
// Flush, the push handshake (in_valid/in_ready/BusMuxOut), the pop
// handshake (out_valid/out_ready), IR, decoded fields and count.
module ir_fetch_queue
    import ir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int REG_W  = 4
) (
    input logic             Clock,
    input logic             Clear,
    ir_fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               pres_valid;
    logic               push, load;

    logic [OPC_W-1:0]   d_opc;
    logic [REG_W-1:0]   d_ra, d_rb, d_rc;
    logic [C_W-1:0]     d_c;
    logic [C2_W-1:0]    d_c2;
    logic [JADDR_W-1:0] d_jaddr;
    logic               d_ill;

    ir_field_decode #(.DATA_W(DATA_W), .REG_W(REG_W)) u_decode (
        .ir      (mem[rd_ptr]),
        .opcode  (d_opc),
        .ra      (d_ra),
        .rb      (d_rb),
        .rc      (d_rc),
        .c       (d_c),
        .c2      (d_c2),
        .jaddr   (d_jaddr),
        .illegal (d_ill)
    );

    // No pop credit: a full buffer refuses a push even when the head
    // is being loaded in the same cycle.
    assign bus.in_ready = (cnt != CNT_W'(DEPTH));
    assign push = bus.in_valid && bus.in_ready && !bus.Flush;
    assign load = (cnt != '0) && (!pres_valid || bus.out_ready) && !bus.Flush;

    always_ff @(posedge Clock) begin
        if (!Clear && push) mem[wr_ptr] <= bus.BusMuxOut;
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            pres_valid <= 1'b0;
            bus.IR     <= '0;
            bus.Opcode <= '0;
            bus.Ra     <= '0;
            bus.Rb     <= '0;
            bus.Rc     <= '0;
            bus.C      <= '0;
            bus.C2     <= '0;
            bus.Jaddr  <= '0;
            bus.Illegal <= 1'b0;
        end else if (bus.Flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            pres_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            case ({push, load})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (load) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                pres_valid  <= 1'b1;
                bus.IR      <= mem[rd_ptr];
                bus.Opcode  <= d_opc;
                bus.Ra      <= d_ra;
                bus.Rb      <= d_rb;
                bus.Rc      <= d_rc;
                bus.C       <= d_c;
                bus.C2      <= d_c2;
                bus.Jaddr   <= d_jaddr;
                bus.Illegal <= d_ill;
            end else if (pres_valid && bus.out_ready) begin
                pres_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = pres_valid;
    assign bus.count     = cnt;

endmodule
